// File: rtl/alu_ex_stage.sv
// alu_ex_stage: EX/MEM stage behind the 32-bit ALU.
//   Two-entry skid buffer (main = head, skid = overflow) with valid/ready on both sides.
//   Sanitises ALU flags at capture. Owns the architectural NZCV register, which is
//   committed in order as the head entry leaves the stage.
// Ports
//   clk, reset (async, active-high), flush (sync, drops all entries)
//   in_*   : ALU result, flags, opcode, set_flags, rd tag, write enable, valid/ready
//   out_*  : head result, rd, wr_en, valid/ready
//   flag_n/z/c/v  : architectural flags
//   flags_pending : some buffered entry will update flags
module alu_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_negative,
  input  logic                  in_zero,
  input  logic                  in_overflow,
  input  logic                  in_cout,
  input  logic [2:0]            in_ctrl,
  input  logic                  in_set_flags,
  input  logic [RD_WIDTH-1:0]   in_rd,
  input  logic                  in_wr_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [RD_WIDTH-1:0]   out_rd,
  output logic                  out_wr_en,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  flags_pending
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [RD_WIDTH-1:0]   rd;
    logic                  wr_en;
    logic                  set_flags;
    logic                  n;
    logic                  z;
    logic                  c;
    logic                  v;
    logic                  arith;
  } ent_t;

  ent_t main_q, skid_q, in_ent;
  logic main_valid, skid_valid;
  logic do_acc, do_rel, arith;

  // C/V are only meaningful for ADD/SUB; gating with arith also keeps an
  // undefined overflow from logic ops out of the registers.
  assign arith = (in_ctrl == 3'd2) || (in_ctrl == 3'd3);

  always_comb begin
    in_ent           = '0;
    in_ent.result    = in_result;
    in_ent.rd        = in_rd;
    in_ent.wr_en     = in_wr_en;
    in_ent.set_flags = in_set_flags;
    in_ent.n         = in_negative;
    in_ent.z         = in_zero;
    in_ent.c         = arith & in_cout;
    in_ent.v         = arith & in_overflow;
    in_ent.arith     = arith;
  end

  // in_ready depends only on state, so out_ready never reaches it combinationally.
  assign in_ready      = ~skid_valid;
  assign out_valid     = main_valid & ~flush;
  assign do_acc        = in_valid & in_ready & ~flush;
  assign do_rel        = out_valid & out_ready;
  assign out_result    = main_q.result;
  assign out_rd        = main_q.rd;
  assign out_wr_en     = main_q.wr_en;
  assign flags_pending = (main_valid & main_q.set_flags) | (skid_valid & skid_q.set_flags);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (do_rel) begin
        if (main_q.set_flags) begin
          flag_n <= main_q.n;
          flag_z <= main_q.z;
          if (main_q.arith) begin
            flag_c <= main_q.c;
            flag_v <= main_q.v;
          end
        end
        // skid full implies in_ready=0, so no accept can collide with the refill
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (do_acc) begin
          main_q     <= in_ent;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (do_acc) begin
        if (main_valid) begin
          skid_q     <= in_ent;
          skid_valid <= 1'b1;
        end else begin
          main_q     <= in_ent;
          main_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: hand-computed expectations per vector.
module tb_alu_ex_stage;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_negative, in_zero, in_overflow, in_cout;
  logic [2:0]  in_ctrl;
  logic        in_set_flags, in_wr_en;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_wr_en;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        flag_n, flag_z, flag_c, flag_v, flags_pending;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_ex_stage #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_negative(in_negative), .in_zero(in_zero), .in_overflow(in_overflow),
    .in_cout(in_cout), .in_ctrl(in_ctrl), .in_set_flags(in_set_flags),
    .in_rd(in_rd), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .flags_pending(flags_pending)
  );

  wire [3:0] nzcv = {flag_n, flag_z, flag_c, flag_v};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] res, input logic [2:0] ctrl, input logic sf,
                       input logic n, input logic z, input logic c, input logic v,
                       input logic [4:0] rd);
    in_valid     = 1'b1;
    in_result    = res;
    in_ctrl      = ctrl;
    in_set_flags = sf;
    in_negative  = n;
    in_zero      = z;
    in_cout      = c;
    in_overflow  = v;
    in_rd        = rd;
    in_wr_en     = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_result = '0;
    in_negative = 1'b0; in_zero = 1'b0; in_overflow = 1'b0; in_cout = 1'b0;
    in_ctrl = 3'd0; in_set_flags = 1'b0; in_rd = '0; in_wr_en = 1'b0; out_ready = 1'b0;
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_nzcv", {28'd0, nzcv}, 32'h0);
    chk("rst_pending", {31'd0, flags_pending}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_wr_en", {31'd0, out_wr_en}, 32'd0);
    reset = 1'b0;
    step();

    // 1: ADD 0x7FFFFFFF+1 -> 0x80000000, N=1 V=1 C=0
    out_ready = 1'b1;
    drive(32'h8000_0000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_result", out_result, 32'h8000_0000);
    chk("t1_out_rd", {27'd0, out_rd}, 32'd3);
    chk("t1_pending", {31'd0, flags_pending}, 32'd1);
    chk("t1_nzcv_before", {28'd0, nzcv}, 32'h0);
    step();
    chk("t1_nzcv", {28'd0, nzcv}, 32'h9);
    chk("t1_drained", {31'd0, out_valid}, 32'd0);
    chk("t1_hold_result", out_result, 32'h8000_0000);

    // 2: XOR result 0, cout=1, overflow undefined -> N=0 Z=1, C/V kept (C=0, V=1)
    drive(32'h0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'bx, 5'd4);
    step();
    in_valid = 1'b0;
    chk("t2_out_result", out_result, 32'h0);
    step();
    chk("t2_nzcv", {28'd0, nzcv}, 32'h5);

    // 3: backpressure fills both entries, third push ignored, drains in order
    out_ready = 1'b0;
    drive(32'h11, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
    step();
    chk("t3_ready_1", {31'd0, in_ready}, 32'd1);
    drive(32'h22, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
    step();
    chk("t3_ready_2", {31'd0, in_ready}, 32'd0);
    drive(32'h33, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    step();
    in_valid = 1'b0;
    chk("t3_still_full", {31'd0, in_ready}, 32'd0);
    chk("t3_head_a", out_result, 32'h11);
    chk("t3_head_a_rd", {27'd0, out_rd}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("t3_head_b", out_result, 32'h22);
    chk("t3_head_b_rd", {27'd0, out_rd}, 32'd2);
    chk("t3_ready_after", {31'd0, in_ready}, 32'd1);
    chk("t3_valid_b", {31'd0, out_valid}, 32'd1);
    step();
    chk("t3_empty", {31'd0, out_valid}, 32'd0);
    chk("t3_no_c", out_result, 32'h22);
    chk("t3_nzcv", {28'd0, nzcv}, 32'h5);

    // 4: streaming accept+release, one result per cycle
    for (int i = 0; i < 8; i++) begin
      drive(32'h100 + i, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'(i));
      step();
      chk("t4_result", out_result, 32'h100 + i);
      chk("t4_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("t4_drained", {31'd0, out_valid}, 32'd0);

    // 5: two SUBs with set_flags buffered, then flush with out_ready high
    out_ready = 1'b0;
    drive(32'h5, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6);
    step();
    step();
    in_valid = 1'b0;
    chk("t5_pending", {31'd0, flags_pending}, 32'd1);
    chk("t5_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("t5_valid_masked", {31'd0, out_valid}, 32'd0);
    step();
    flush = 1'b0;
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_pending_clr", {31'd0, flags_pending}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_nzcv", {28'd0, nzcv}, 32'h5);
    step();
    chk("t5_nzcv_kept", {28'd0, nzcv}, 32'h5);

    // 6: async reset while skid full
    out_ready = 1'b0;
    drive(32'h66, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7);
    step();
    step();
    in_valid = 1'b0;
    chk("t6_full", {31'd0, in_ready}, 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_nzcv", {28'd0, nzcv}, 32'h0);
    chk("t6_pending", {31'd0, flags_pending}, 32'd0);
    chk("t6_result", out_result, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_valid_after", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
